spart_rx_fifo: RTL and testbench
================================

Name: spart_rx_fifo

Overview:
Receive-side buffer between the SPART serial receiver and the bus interface/driver.
- Captures each byte the receiver completes, along with its framing-error flag, into a small circular FIFO.
- Presents the oldest byte in first-word-fall-through form and drives the rda status seen by the driver.
- Absorbs back-to-back received characters (e.g. A5, E7, 24 at the fastest br_cfg) while the driver is slow to read.

Parameters:
DEPTH, 8, number of byte entries; power of two, minimum 2
PTR_W, 3, pointer width, log2(DEPTH)
DATA_W, 8, byte width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
rx_done  in  1  receiver byte-complete strobe; may stay high more than 1 cycle
rx_data  in  DATA_W  received byte; valid while rx_done is high
rx_ferr  in  1  stop bit sampled low for this byte; valid with rx_done
rd_pop  in  1  bus interface consumed the head byte (iocs & iorw read of the receive buffer)
clr_status  in  1  clears the sticky overrun and framing-error flags
rd_data  out  DATA_W  head byte (FWFT)
rd_ferr  out  1  framing-error bit stored with the head byte
rda  out  1  receive data available (FIFO not empty)
full  out  1  FIFO holds DEPTH entries
count  out  PTR_W+1  occupancy, 0..DEPTH
overrun  out  1  sticky: at least one byte dropped because the FIFO was full
ferr_sticky  out  1  sticky: at least one byte accepted with rx_ferr=1

Behaviour:
- Reset: all state updates on posedge clk only while rst==0.
  - Reset values: wr_ptr=0, rd_ptr=0, count=0, rda=0, full=0, overrun=0, ferr_sticky=0, edge-detect register=0.
  - Memory contents are not reset. rd_data/rd_ferr are don't-care while rda==0.
- Reset mid-operation discards all stored bytes and any push/pop in that cycle.
- Push detection: register rx_done_q. Push request = rx_done & ~rx_done_q. Exactly one push per high period of rx_done, regardless of length. rx_data/rx_ferr are sampled in the rising-edge cycle.
- Pop request = rd_pop (level; each high cycle is one pop).
  - Pop when count==0 is ignored: no pointer change, no flag.
- Push when not full:
  - Write {rx_ferr, rx_data} to mem[wr_ptr]; wr_ptr += 1, wrapping modulo DEPTH.
  - ferr_sticky |= rx_ferr.
- Push when full:
  - Without a simultaneous valid pop: byte dropped, overrun <= 1, no pointer change.
  - With a simultaneous pop: both proceed and count is unchanged.
- Pop: rd_ptr += 1, wrapping.
- Count update:
  - push only: count+1
  - pop only: count-1
  - both, or neither: unchanged
  - Push into an empty FIFO with rd_pop high: pop ignored, push performed, count becomes 1.
- Derived outputs: rda = (count != 0); full = (count == DEPTH). Both come from registered count, so no combinational path from inputs.
- Read data: rd_data = mem[rd_ptr][DATA_W-1:0], rd_ferr = mem[rd_ptr][DATA_W], combinational read of the register array.
- Latency:
  - rx_done rising at edge N (sampled at posedge N): rda=1 and rd_data valid after posedge N.
  - Pop at posedge M: next byte on rd_data after posedge M.
- clr_status: overrun and ferr_sticky <= 0 next edge. A simultaneous setting event wins (flag stays 1).
- Wrap-around: pointers use PTR_W bits; full/empty are distinguished by count only.

Test Plan:
- Reset check: hold rst=0 for 2 clks, then rst=1 -> rda=0, full=0, count=0, overrun=0, ferr_sticky=0.
- Three bytes, rx_done held 3 cycles each: push A5, E7, 24, then pop 3 times -> rd_data sequence A5, E7, 24. count goes 1,2,3, then 2,1,0. rda falls after the third pop. Exactly 3 pushes.
- Overrun: push 8 bytes 00..07 (full=1), push 0x55 -> overrun=1, count=8. Then pop all 8 -> rd_data 00..07; 0x55 is never seen. clr_status -> overrun=0.
- Simultaneous full: with full=1, push 0x99 and pop in the same cycle -> count stays 8, head advances to 01, and 0x99 emerges last. overrun stays 0.
- Wrap and empty pop:
  - Push/pop 20 bytes 0x10..0x23 one at a time -> each read correct across pointer wrap.
  - rd_pop with count=0 -> count stays 0, rda=0.
  - Push 0x42 with rd_pop high while empty -> count=1, rd_data=42.
- Framing error: push 0x7E with rx_ferr=1 -> rd_ferr=1 at head, ferr_sticky=1. Push 0x3C with rx_ferr=0 -> ferr_sticky stays 1. clr_status coincident with another ferr push -> ferr_sticky remains 1.

Source files
------------

// File: rtl/spart_rx_fifo_if.sv
// Handshake bundle between the SPART receiver/bus side and the receive FIFO.
// The slave modport is the FIFO's view, and the master modport is the side that drives it.
interface spart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 3
);
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ferr;
    logic              rd_pop;
    logic              clr_status;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ferr;
    logic              rda;
    logic              full;
    logic [PTR_W:0]    count;
    logic              overrun;
    logic              ferr_sticky;

    modport master (
        output rx_done, rx_data, rx_ferr, rd_pop, clr_status,
        input  rd_data, rd_ferr, rda, full, count, overrun, ferr_sticky
    );

    modport slave (
        input  rx_done, rx_data, rx_ferr, rd_pop, clr_status,
        output rd_data, rd_ferr, rda, full, count, overrun, ferr_sticky
    );
endinterface

// File: rtl/spart_rx_fifo.sv
// SPART receive buffer: a circular FWFT FIFO of {ferr, byte} entries.
// It provides sticky overrun and framing-error status.
module spart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int DATA_W = 8
) (
    input logic clk,
    input logic rst,
    spart_rx_fifo_if.slave bus
);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [DATA_W:0]    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count_r;
    logic               rx_done_q;
    logic               overrun_r;
    logic               ferr_r;

    logic push_req;
    logic pop_ok;
    logic is_full;
    logic push_ok;
    logic drop;

    // rx_done may be held for several cycles, so only its rising edge counts as a push.
    assign push_req = bus.rx_done & ~rx_done_q;
    assign pop_ok   = bus.rd_pop & (count_r != '0);
    assign is_full  = (count_r == CNT_FULL);
    assign push_ok  = push_req & (~is_full | pop_ok);
    assign drop     = push_req & is_full & ~pop_ok;

    // The storage array has no reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (rst && push_ok)
            mem[wr_ptr] <= {bus.rx_ferr, bus.rx_data};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_r   <= '0;
            rx_done_q <= 1'b0;
            overrun_r <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            rx_done_q <= bus.rx_done;
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok)
                count_r <= count_r + CNT_ONE;
            else if (pop_ok && !push_ok)
                count_r <= count_r - CNT_ONE;
            // A setting event in the same cycle takes priority over clr_status.
            overrun_r <= drop | (overrun_r & ~bus.clr_status);
            ferr_r    <= (push_ok & bus.rx_ferr) | (ferr_r & ~bus.clr_status);
        end
    end

    assign bus.rd_data     = mem[rd_ptr][DATA_W-1:0];
    assign bus.rd_ferr     = mem[rd_ptr][DATA_W];
    assign bus.rda         = (count_r != '0);
    assign bus.full        = is_full;
    assign bus.count       = count_r;
    assign bus.overrun     = overrun_r;
    assign bus.ferr_sticky = ferr_r;
endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed testbench for spart_rx_fifo.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_spart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    spart_rx_fifo_if #(.DATA_W(8), .PTR_W(3)) bus ();

    spart_rx_fifo #(.DEPTH(8), .PTR_W(3), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold rx_done for `hold` cycles, then drop it for one cycle.
    task automatic push(input logic [7:0] b, input logic fe, input int hold);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        bus.rx_ferr = fe;
        repeat (hold) tick();
        bus.rx_done = 1'b0;
        bus.rx_ferr = 1'b0;
        tick();
    endtask

    task automatic pop();
        bus.rd_pop = 1'b1;
        tick();
        bus.rd_pop = 1'b0;
    endtask

    task automatic clear();
        bus.clr_status = 1'b1;
        tick();
        bus.clr_status = 1'b0;
    endtask

    initial begin
        logic [7:0] seq3 [3];
        seq3[0] = 8'hA5; seq3[1] = 8'hE7; seq3[2] = 8'h24;
        bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.rx_ferr = 1'b0;
        bus.rd_pop = 1'b0;  bus.clr_status = 1'b0;

        // Reset
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rst_rda", 32'(bus.rda), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_ferr_sticky", 32'(bus.ferr_sticky), 0);

        // Three bytes, rx_done held 3 cycles each
        for (int i = 0; i < 3; i++) begin
            push(seq3[i], 1'b0, 3);
            check("three_count_up", 32'(bus.count), 32'(i + 1));
            check("three_rda", 32'(bus.rda), 1);
        end
        check("three_head", 32'(bus.rd_data), 32'h A5);
        for (int i = 0; i < 3; i++) begin
            check("three_data", 32'(bus.rd_data), 32'(seq3[i]));
            pop();
            check("three_count_dn", 32'(bus.count), 32'(2 - i));
        end
        check("three_rda_low", 32'(bus.rda), 0);

        // Overrun
        for (int i = 0; i < 8; i++) push(8'(i), 1'b0, 1);
        check("ovr_full", 32'(bus.full), 1);
        check("ovr_count8", 32'(bus.count), 8);
        check("ovr_flag0", 32'(bus.overrun), 0);
        push(8'h55, 1'b0, 1);
        check("ovr_flag1", 32'(bus.overrun), 1);
        check("ovr_count_hold", 32'(bus.count), 8);
        for (int i = 0; i < 8; i++) begin
            check("ovr_data", 32'(bus.rd_data), 32'(i));
            pop();
        end
        check("ovr_empty", 32'(bus.count), 0);
        check("ovr_rda0", 32'(bus.rda), 0);
        clear();
        check("ovr_clr", 32'(bus.overrun), 0);

        // Push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) push(8'(i), 1'b0, 1);
        check("sim_full", 32'(bus.full), 1);
        bus.rx_done = 1'b1; bus.rx_data = 8'h99; bus.rd_pop = 1'b1;
        tick();
        bus.rx_done = 1'b0; bus.rd_pop = 1'b0;
        tick();
        check("sim_count", 32'(bus.count), 8);
        check("sim_head", 32'(bus.rd_data), 32'h01);
        check("sim_overrun", 32'(bus.overrun), 0);
        for (int i = 1; i < 8; i++) begin
            check("sim_data", 32'(bus.rd_data), 32'(i));
            pop();
        end
        check("sim_last", 32'(bus.rd_data), 32'h99);
        pop();
        check("sim_empty", 32'(bus.count), 0);

        // Wrap-around, one byte at a time
        for (int i = 0; i < 20; i++) begin
            push(8'(16 + i), 1'b0, 1);
            check("wrap_data", 32'(bus.rd_data), 32'(16 + i));
            check("wrap_count1", 32'(bus.count), 1);
            pop();
        end
        check("wrap_empty", 32'(bus.count), 0);

        // Popping an empty FIFO
        pop();
        check("epop_count", 32'(bus.count), 0);
        check("epop_rda", 32'(bus.rda), 0);

        // Push into an empty FIFO with rd_pop high
        bus.rx_done = 1'b1; bus.rx_data = 8'h42; bus.rd_pop = 1'b1;
        tick();
        bus.rx_done = 1'b0; bus.rd_pop = 1'b0;
        tick();
        check("epush_count", 32'(bus.count), 1);
        check("epush_data", 32'(bus.rd_data), 32'h42);
        pop();
        check("epush_drain", 32'(bus.count), 0);

        // Framing-error capture and sticky flag
        check("fe_sticky0", 32'(bus.ferr_sticky), 0);
        push(8'h7E, 1'b1, 1);
        check("fe_head_data", 32'(bus.rd_data), 32'h7E);
        check("fe_head_ferr", 32'(bus.rd_ferr), 1);
        check("fe_sticky1", 32'(bus.ferr_sticky), 1);
        push(8'h3C, 1'b0, 1);
        check("fe_sticky_hold", 32'(bus.ferr_sticky), 1);
        clear();
        check("fe_clr", 32'(bus.ferr_sticky), 0);
        bus.rx_done = 1'b1; bus.rx_data = 8'h81; bus.rx_ferr = 1'b1; bus.clr_status = 1'b1;
        tick();
        bus.rx_done = 1'b0; bus.rx_ferr = 1'b0; bus.clr_status = 1'b0;
        tick();
        check("fe_set_wins", 32'(bus.ferr_sticky), 1);
        check("fe_count3", 32'(bus.count), 3);
        pop();
        check("fe_second_data", 32'(bus.rd_data), 32'h3C);
        check("fe_second_ferr", 32'(bus.rd_ferr), 0);
        pop();
        check("fe_third_ferr", 32'(bus.rd_ferr), 1);

        // Reset in mid-operation discards stored bytes
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mrst_count", 32'(bus.count), 0);
        check("mrst_sticky", 32'(bus.ferr_sticky), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
